// File: rtl/multitone_tester_pkg.sv
// Shared definitions for the multitone tester: FSM encoding, width helper and
// saturating arithmetic used by the counter bank and the score scan.
package multitone_tester_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_SCORE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Smallest r with 2**r >= value; bounded loop so it stays elaboration-friendly.
  function automatic int clog2(input int unsigned value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      r = ((64'd1 << i) < 64'(value)) ? (i + 1) : r;
    end
    return r;
  endfunction

  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned width);
    logic [64:0] sum;
    logic [64:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (65'd1 << width) - 65'd1;
    if (sum > lim) begin
      return lim[63:0];
    end else begin
      return sum[63:0];
    end
  endfunction

endpackage

// File: rtl/multitone_tester_if.sv
// Host-side bus of the multitone tester: control, DUT stimulus/response and readback.
interface multitone_tester_if #(
  parameter int NUM_TONES = 4,
  parameter int CNT_WIDTH = 32
);
  import multitone_tester_pkg::*;

  localparam int SEL_W = clog2(NUM_TONES);

  logic                 start;
  logic                 abort;
  logic                 mode;
  logic                 test_out;
  logic                 test_in;
  logic [SEL_W-1:0]     select;
  logic                 busy;
  logic                 done;
  logic [CNT_WIDTH-1:0] score;
  logic [SEL_W-1:0]     rd_idx;
  logic [CNT_WIDTH-1:0] rd_count;

  modport slave (
    input  start, abort, mode, test_out, rd_idx,
    output test_in, select, busy, done, score, rd_count
  );

  modport master (
    output start, abort, mode, test_out, rd_idx,
    input  test_in, select, busy, done, score, rd_count
  );

endinterface

// File: rtl/multitone_tester_tone_gen.sv
// Square-wave generator with a loadable half-period; restart forces the wave low
// and rewinds the phase so every window begins with a full low half-cycle.
module multitone_tester_tone_gen #(
  parameter int HP_W = 8
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            restart_i,
  input  logic [HP_W-1:0] half_period_i,
  output logic            tone_o
);

  logic [HP_W-1:0] phase_q, phase_d;
  logic            tone_q, tone_d;

  // Phase advance and toggle decision
  always_comb begin
    phase_d = phase_q;
    tone_d  = tone_q;
    if (restart_i) begin
      phase_d = {HP_W{1'b0}};
      tone_d  = 1'b0;
    end else if (phase_q >= (half_period_i - HP_W'(1))) begin
      phase_d = {HP_W{1'b0}};
      tone_d  = ~tone_q;
    end else begin
      phase_d = phase_q + HP_W'(1);
      tone_d  = tone_q;
    end
  end

  // Phase/tone state registers
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      phase_q <= {HP_W{1'b0}};
      tone_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      tone_q  <= tone_d;
    end
  end

  assign tone_o = tone_q;

endmodule

// File: rtl/multitone_tester.sv
// Multitone tester: plays one tone per window into the DUT, counts its 1s after
// a settle interval, then scans the per-tone counts into a single score.
module multitone_tester
  import multitone_tester_pkg::*;
#(
  parameter int NUM_TONES = 4,
  parameter int HALF0     = 250,
  parameter int LOG2_STEP = 3,
  parameter int WINDOW    = 1000000,
  parameter int SETTLE    = 1000,
  parameter int CNT_WIDTH = 32
) (
  input logic               clock_i,
  input logic               reset_i,
  multitone_tester_if.slave bus
);

  localparam int SEL_W    = clog2(NUM_TONES);
  localparam int TMR_W    = clog2(WINDOW);
  localparam int HALF_MAX = HALF0 << ((NUM_TONES - 1) * LOG2_STEP);
  localparam int HP_W     = clog2(HALF_MAX + 1);
  localparam logic [SEL_W-1:0] LAST_SEL   = SEL_W'(NUM_TONES - 1);
  localparam logic [TMR_W-1:0] LAST_TMR   = TMR_W'(WINDOW - 1);
  localparam logic [TMR_W-1:0] SETTLE_TMR = TMR_W'(SETTLE);

  logic [1:0]           state_q, state_d;
  logic [SEL_W-1:0]     select_q, select_d;
  logic [SEL_W-1:0]     scan_q, scan_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [CNT_WIDTH-1:0] cnt_q [NUM_TONES];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_TONES];
  logic [CNT_WIDTH-1:0] max_q, max_d, min_q, min_d, acc_q, acc_d, score_q, score_d;
  logic                 mode_q, mode_d, done_q, done_d, busy_q, busy_d;
  logic                 wrap_s, restart_s, tone_s;
  logic [HP_W-1:0]      half_s;
  logic [CNT_WIDTH-1:0] cur_s, prev_s, diff_s;

  // Half-period of the tone selected for the current window
  always_comb begin
    half_s = HP_W'(HALF0);
    for (int i = 0; i < NUM_TONES; i++) begin
      half_s = (select_q == SEL_W'(i)) ? HP_W'(HALF0 << (i * LOG2_STEP)) : half_s;
    end
  end

  // Operands for the score scan: current count and its predecessor
  always_comb begin
    cur_s  = cnt_q[scan_q];
    prev_s = (scan_q == SEL_W'(0)) ? cur_s : cnt_q[scan_q - SEL_W'(1)];
    diff_s = (cur_s >= prev_s) ? (cur_s - prev_s) : (prev_s - cur_s);
  end

  // Next-state logic: FSM, window timer, counter bank and score scan
  always_comb begin
    state_d  = state_q;
    select_d = select_q;
    scan_d   = scan_q;
    timer_d  = timer_q;
    max_d    = max_q;
    min_d    = min_q;
    acc_d    = acc_q;
    score_d  = score_q;
    mode_d   = mode_q;
    done_d   = done_q;
    wrap_s   = 1'b0;
    for (int i = 0; i < NUM_TONES; i++) begin
      cnt_d[i] = cnt_q[i];
    end

    if (bus.abort) begin
      // Abort wins over everything; counts are deliberately left readable.
      state_d  = ST_IDLE;
      select_d = {SEL_W{1'b0}};
      timer_d  = {TMR_W{1'b0}};
      done_d   = 1'b0;
      score_d  = {CNT_WIDTH{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state_d  = ST_RUN;
            select_d = {SEL_W{1'b0}};
            timer_d  = {TMR_W{1'b0}};
            done_d   = 1'b0;
            score_d  = {CNT_WIDTH{1'b0}};
            for (int i = 0; i < NUM_TONES; i++) begin
              cnt_d[i] = {CNT_WIDTH{1'b0}};
            end
          end else begin
            state_d = state_q;
          end
        end
        ST_RUN: begin
          if (timer_q >= SETTLE_TMR) begin
            cnt_d[select_q] = CNT_WIDTH'(sat_add(64'(cnt_q[select_q]), 64'(bus.test_out),
                                                 CNT_WIDTH));
          end else begin
            cnt_d[select_q] = cnt_q[select_q];
          end
          if (timer_q == LAST_TMR) begin
            wrap_s  = 1'b1;
            timer_d = {TMR_W{1'b0}};
            if (select_q == LAST_SEL) begin
              state_d = ST_SCORE;
              scan_d  = {SEL_W{1'b0}};
              mode_d  = bus.mode;
            end else begin
              select_d = select_q + SEL_W'(1);
            end
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
        ST_SCORE: begin
          if (scan_q == SEL_W'(0)) begin
            max_d = cur_s;
            min_d = cur_s;
            acc_d = {CNT_WIDTH{1'b0}};
          end else begin
            max_d = (cur_s > max_q) ? cur_s : max_q;
            min_d = (cur_s < min_q) ? cur_s : min_q;
            acc_d = CNT_WIDTH'(sat_add(64'(acc_q), 64'(diff_s), CNT_WIDTH));
          end
          if (scan_q == LAST_SEL) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            score_d = mode_q ? acc_d : (max_d - min_d);
          end else begin
            scan_d = scan_q + SEL_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d    = (state_d == ST_RUN) || (state_d == ST_SCORE);
    restart_s = wrap_s || (state_q != ST_RUN) || (state_d != ST_RUN);
  end

  // State registers
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      select_q <= {SEL_W{1'b0}};
      scan_q   <= {SEL_W{1'b0}};
      timer_q  <= {TMR_W{1'b0}};
      max_q    <= {CNT_WIDTH{1'b0}};
      min_q    <= {CNT_WIDTH{1'b0}};
      acc_q    <= {CNT_WIDTH{1'b0}};
      score_q  <= {CNT_WIDTH{1'b0}};
      mode_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      for (int i = 0; i < NUM_TONES; i++) begin
        cnt_q[i] <= {CNT_WIDTH{1'b0}};
      end
    end else begin
      state_q  <= state_d;
      select_q <= select_d;
      scan_q   <= scan_d;
      timer_q  <= timer_d;
      max_q    <= max_d;
      min_q    <= min_d;
      acc_q    <= acc_d;
      score_q  <= score_d;
      mode_q   <= mode_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      for (int i = 0; i < NUM_TONES; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  multitone_tester_tone_gen #(
    .HP_W(HP_W)
  ) u_tone_gen (
    .clock_i       (clock_i),
    .reset_i       (reset_i),
    .restart_i     (restart_s),
    .half_period_i (half_s),
    .tone_o        (tone_s)
  );

  assign bus.test_in  = tone_s;
  assign bus.select   = select_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.score    = score_q;
  assign bus.rd_count = (int'(bus.rd_idx) < NUM_TONES) ? cnt_q[bus.rd_idx] : {CNT_WIDTH{1'b0}};

endmodule
